// File: rtl/note_step_sequencer_pkg.sv
// Shared types and constants for the note step sequencer: FSM states,
// rest threshold and the octave-7 tone half-period table.
package synth_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_PLAY  = 2'd2,
    ST_PAUSE = 2'd3
  } state_t;

  // Semitone codes at or above this value are rests.
  localparam logic [3:0] NOTE_REST = 4'd12;

  // Pattern entry meaning "rest, no tie"; also the cleared pattern value.
  localparam logic [7:0] REST_ENTRY = 8'h0F;

  // Octave-7 half-periods at 100 MHz, C7 .. B7.
  localparam logic [15:0] BASE_PERIOD [0:11] = '{
    16'd23889, 16'd22548, 16'd21283, 16'd20088, 16'd18961, 16'd17897,
    16'd16892, 16'd15944, 16'd15049, 16'd14205, 16'd13407, 16'd12655
  };

  // Tone divider period word for a note: the octave-7 base scaled by 2^(7-oct).
  function automatic logic [31:0] note_period(input logic [2:0] oct, input logic [3:0] semi);
    logic [31:0] base;
    base = 32'd0;
    if (semi < NOTE_REST) begin
      base = {16'd0, BASE_PERIOD[semi]};
    end else begin
      base = 32'd0;
    end
    return base << (3'd7 - oct);
  endfunction

endpackage

// File: rtl/note_step_sequencer_if.sv
// Control, pattern-write and tone-output bundle of the note step sequencer.
// master = user/control side, slave = sequencer.
interface note_step_sequencer_if #(parameter int AW = 4);
  logic          start;
  logic          stop;
  logic          pause;
  logic          loop_en;
  logic [AW-1:0] len;
  logic          step_tick;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [7:0]    wr_data;
  logic [31:0]   tone_num;
  logic          tone_rst_n;
  logic          gate;
  logic [AW-1:0] cur_step;
  logic          busy;
  logic          done;

  modport master (
    output start, stop, pause, loop_en, len, step_tick, wr_en, wr_addr, wr_data,
    input  tone_num, tone_rst_n, gate, cur_step, busy, done
  );

  modport slave (
    input  start, stop, pause, loop_en, len, step_tick, wr_en, wr_addr, wr_data,
    output tone_num, tone_rst_n, gate, cur_step, busy, done
  );
endinterface

// File: rtl/note_step_sequencer_pattern_ram.sv
// Note pattern storage: STEPS x 8 registers, one write port and one
// registered read port. A same-edge write to the read address returns the
// old contents, because both use the pre-edge array value.
module pattern_ram
  import synth_pkg::*;
#(
  parameter int STEPS = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data
);

  logic [7:0] mem_r [STEPS];
  logic [7:0] rd_data_r;

  // Pattern write and registered read; reset clears every entry to a rest.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < STEPS; i++) begin
        mem_r[i] <= REST_ENTRY;
      end
      rd_data_r <= REST_ENTRY;
    end else begin
      if (wr_en) begin
        mem_r[wr_addr] <= wr_data;
      end
      rd_data_r <= mem_r[rd_addr];
    end
  end

  assign rd_data = rd_data_r;

endmodule

// File: rtl/note_step_sequencer.sv
// Note step sequencer: walks the programmed pattern one step per step_tick
// and drives the tone divider's period word, phase restart and note gate.
module note_step_sequencer
  import synth_pkg::*;
#(
  parameter int STEPS = 16,
  parameter int AW    = 4
) (
  input logic                 clk,
  input logic                 rst_n,
  note_step_sequencer_if.slave bus
);

  state_t        state_r, state_s;
  logic [AW-1:0] cur_step_r, cur_step_s;
  logic [31:0]   tone_num_r, tone_num_s;
  logic          tone_rst_n_r, tone_rst_n_s;
  logic          gate_r, gate_s;
  logic          done_r, done_s;
  logic          busy_r, busy_s;
  logic [6:0]    note_r, note_s;   // {oct, semi} of the step now held
  logic          rest_r, rest_s;   // held step is a rest (or no step yet)

  logic [7:0]    rd_data_s;
  logic          fetch_rest_s;
  logic          fetch_tie_s;
  logic [31:0]   fetch_period_s;

  // The RAM is addressed with the next step index so the entry is already
  // registered by the time the FETCH cycle ends.
  pattern_ram #(.STEPS(STEPS), .AW(AW)) u_pattern_ram (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (bus.wr_en),
    .wr_addr (bus.wr_addr),
    .wr_data (bus.wr_data),
    .rd_addr (cur_step_s),
    .rd_data (rd_data_s)
  );

  assign fetch_rest_s   = (rd_data_s[3:0] >= NOTE_REST);
  assign fetch_tie_s    = rd_data_s[7] && !rest_r && (rd_data_s[6:0] == note_r);
  assign fetch_period_s = note_period(rd_data_s[6:4], rd_data_s[3:0]);

  // Next-state and next-output logic; stop overrides every state.
  always_comb begin
    state_s      = state_r;
    cur_step_s   = cur_step_r;
    tone_num_s   = tone_num_r;
    tone_rst_n_s = 1'b1;
    gate_s       = gate_r;
    done_s       = 1'b0;
    note_s       = note_r;
    rest_s       = rest_r;
    if (bus.stop) begin
      state_s    = ST_IDLE;
      cur_step_s = {AW{1'b0}};
      gate_s     = 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (bus.start) begin
            state_s    = ST_FETCH;
            cur_step_s = {AW{1'b0}};
            rest_s     = 1'b1;   // nothing sounding yet, so step 0 cannot tie
          end else begin
            state_s = ST_IDLE;
          end
        end
        ST_FETCH: begin
          state_s      = ST_PLAY;
          note_s       = rd_data_s[6:0];
          rest_s       = fetch_rest_s;
          gate_s       = !fetch_rest_s;
          tone_rst_n_s = fetch_tie_s;
          if (!fetch_rest_s) begin
            tone_num_s = fetch_period_s;
          end else begin
            tone_num_s = tone_num_r;
          end
        end
        ST_PLAY: begin
          if (bus.pause) begin
            state_s = ST_PAUSE;
            gate_s  = 1'b0;
          end else if (bus.step_tick) begin
            if (cur_step_r < bus.len) begin
              state_s    = ST_FETCH;
              cur_step_s = cur_step_r + {{(AW-1){1'b0}}, 1'b1};
            end else if (bus.loop_en) begin
              state_s    = ST_FETCH;
              cur_step_s = {AW{1'b0}};
            end else begin
              state_s    = ST_IDLE;
              cur_step_s = {AW{1'b0}};
              gate_s     = 1'b0;
              done_s     = 1'b1;
            end
          end else begin
            state_s = ST_PLAY;
          end
        end
        ST_PAUSE: begin
          if (bus.pause || bus.start) begin
            state_s      = ST_PLAY;
            gate_s       = !rest_r;
            tone_rst_n_s = 1'b0;
          end else begin
            state_s = ST_PAUSE;
          end
        end
        default: begin
          state_s    = ST_IDLE;
          cur_step_s = {AW{1'b0}};
          gate_s     = 1'b0;
        end
      endcase
    end
    busy_s = (state_s != ST_IDLE);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      cur_step_r   <= {AW{1'b0}};
      tone_num_r   <= 32'd0;
      tone_rst_n_r <= 1'b1;
      gate_r       <= 1'b0;
      done_r       <= 1'b0;
      busy_r       <= 1'b0;
      note_r       <= 7'd0;
      rest_r       <= 1'b1;
    end else begin
      state_r      <= state_s;
      cur_step_r   <= cur_step_s;
      tone_num_r   <= tone_num_s;
      tone_rst_n_r <= tone_rst_n_s;
      gate_r       <= gate_s;
      done_r       <= done_s;
      busy_r       <= busy_s;
      note_r       <= note_s;
      rest_r       <= rest_s;
    end
  end

  assign bus.tone_num   = tone_num_r;
  assign bus.tone_rst_n = tone_rst_n_r;
  assign bus.gate       = gate_r;
  assign bus.cur_step   = cur_step_r;
  assign bus.busy       = busy_r;
  assign bus.done       = done_r;

endmodule

// File: tb/tb_note_step_sequencer.sv
// Self-checking bench for note_step_sequencer: directed scenarios plus
// randomized patterns, checked against a step-level behavioural model.
module tb_note_step_sequencer;
  localparam int AW = 4;

  logic clk = 1'b0;
  logic rst_n;

  note_step_sequencer_if #(.AW(AW)) bus();

  note_step_sequencer #(.STEPS(16), .AW(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;

  // Reference model state: pattern contents and the last loaded period word.
  logic [7:0]  m_pat [16];
  int unsigned m_tone;
  int unsigned base_tbl [12] = '{23889, 22548, 21283, 20088, 18961, 17897,
                                 16892, 15944, 15049, 14205, 13407, 12655};

  function automatic int unsigned ref_period(input logic [7:0] d);
    int sh;
    sh = 7 - int'(d[6:4]);
    return base_tbl[d[3:0]] * (32'd1 << sh);
  endfunction

  function automatic bit is_rest(input logic [7:0] d);
    return (d[3:0] >= 4'd12);
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.start = 1'b0; bus.stop = 1'b0; bus.pause = 1'b0; bus.loop_en = 1'b0;
    bus.len = '0; bus.step_tick = 1'b0; bus.wr_en = 1'b0; bus.wr_addr = '0;
    bus.wr_data = 8'h00;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_inputs();
    cyc();
    cyc();
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) m_pat[i] = 8'h0F;
    m_tone = 0;
  endtask

  task automatic wr_step(input int a, input logic [7:0] d);
    bus.wr_en = 1'b1; bus.wr_addr = AW'(a); bus.wr_data = d;
    cyc();
    bus.wr_en = 1'b0;
    m_pat[a] = d;
  endtask

  // Play the model pattern from step 0 with nticks step_ticks, checking each step.
  task automatic run_pattern(input int len, input bit lp, input int nticks, input string tag);
    int s; bit prev_ok; logic [6:0] prev_note; bit g; logic [7:0] d; bit rest; bit tie;
    s = 0; prev_ok = 0; prev_note = 7'd0; g = 0;
    bus.len = AW'(len); bus.loop_en = lp;
    bus.start = 1'b1; cyc(); bus.start = 1'b0;
    tests_run++;
    if (bus.gate !== g || bus.tone_rst_n !== 1'b1 || bus.busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL %s start_fetch: gate=%0b rst_n=%0b busy=%0b expected gate=%0b rst_n=1 busy=1",
               tag, bus.gate, bus.tone_rst_n, bus.busy, g);
    end
    for (int k = 0; k <= nticks; k++) begin
      cyc();
      d = m_pat[s]; rest = is_rest(d);
      tie = d[7] && prev_ok && (d[6:0] == prev_note);
      if (!rest) m_tone = ref_period(d);
      tests_run++;
      if (bus.cur_step !== AW'(s) || bus.tone_num !== m_tone || bus.gate !== !rest ||
          bus.tone_rst_n !== tie) begin
        tests_failed++;
        $display("FAIL %s step%0d: cur=%0d tone=%0d gate=%0b rst_n=%0b expected cur=%0d tone=%0d gate=%0b rst_n=%0b",
                 tag, k, bus.cur_step, bus.tone_num, bus.gate, bus.tone_rst_n, s, m_tone, !rest, tie);
      end
      prev_ok = !rest; prev_note = d[6:0]; g = !rest;
      repeat ($urandom_range(0, 2)) begin
        cyc();
        tests_run++;
        if (bus.tone_rst_n !== 1'b1 || bus.gate !== g || bus.tone_num !== m_tone) begin
          tests_failed++;
          $display("FAIL %s hold%0d: rst_n=%0b gate=%0b tone=%0d expected rst_n=1 gate=%0b tone=%0d",
                   tag, k, bus.tone_rst_n, bus.gate, bus.tone_num, g, m_tone);
        end
      end
      if (k < nticks) begin
        bus.step_tick = 1'b1; cyc(); bus.step_tick = 1'b0;
        if (s < len) s++;
        else if (lp) s = 0;
        else begin
          tests_run++;
          if (bus.done !== 1'b1 || bus.gate !== 1'b0 || bus.busy !== 1'b0 || bus.cur_step !== '0) begin
            tests_failed++;
            $display("FAIL %s end: done=%0b gate=%0b busy=%0b cur=%0d expected done=1 gate=0 busy=0 cur=0",
                     tag, bus.done, bus.gate, bus.busy, bus.cur_step);
          end
          cyc();
          tests_run++;
          if (bus.done !== 1'b0) begin
            tests_failed++;
            $display("FAIL %s done_width: done=%0b expected 0", tag, bus.done);
          end
          return;
        end
        tests_run++;
        if (bus.gate !== g || bus.tone_rst_n !== 1'b1 || bus.cur_step !== AW'(s)) begin
          tests_failed++;
          $display("FAIL %s fetch%0d: gate=%0b rst_n=%0b cur=%0d expected gate=%0b rst_n=1 cur=%0d",
                   tag, k, bus.gate, bus.tone_rst_n, bus.cur_step, g, s);
        end
      end
    end
    bus.stop = 1'b1; cyc(); bus.stop = 1'b0;
    tests_run++;
    if (bus.busy !== 1'b0 || bus.gate !== 1'b0 || bus.cur_step !== '0 || bus.done !== 1'b0) begin
      tests_failed++;
      $display("FAIL %s stop: busy=%0b gate=%0b cur=%0d done=%0b expected 0 0 0 0",
               tag, bus.busy, bus.gate, bus.cur_step, bus.done);
    end
  endtask

  task automatic test_reset();
    do_reset();
    tests_run++;
    if (bus.tone_num !== 32'd0 || bus.tone_rst_n !== 1'b1 || bus.gate !== 1'b0 ||
        bus.cur_step !== '0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset: tone=%0d rst_n=%0b gate=%0b cur=%0d busy=%0b done=%0b expected 0 1 0 0 0 0",
               bus.tone_num, bus.tone_rst_n, bus.gate, bus.cur_step, bus.busy, bus.done);
    end
  endtask

  task automatic test_single();
    wr_step(0, 8'h70);
    run_pattern(0, 1'b0, 1, "single");
  endtask

  task automatic test_pattern();
    wr_step(0, 8'h40); wr_step(1, 8'h0F); wr_step(2, 8'h71); wr_step(3, 8'h4B);
    run_pattern(3, 1'b1, 5, "pattern");
  endtask

  task automatic test_tie();
    wr_step(0, 8'h52); wr_step(1, 8'hD2);
    run_pattern(1, 1'b0, 2, "tie");
  endtask

  task automatic test_pause();
    int unsigned t0;
    wr_step(0, 8'h63); wr_step(1, 8'h55);
    t0 = ref_period(8'h63);
    bus.len = AW'(1); bus.loop_en = 1'b1;
    bus.start = 1'b1; cyc(); bus.start = 1'b0; cyc(); cyc();
    bus.pause = 1'b1; cyc(); bus.pause = 1'b0;
    tests_run++;
    if (bus.gate !== 1'b0 || bus.busy !== 1'b1 || bus.cur_step !== '0) begin
      tests_failed++;
      $display("FAIL pause_enter: gate=%0b busy=%0b cur=%0d expected 0 1 0", bus.gate, bus.busy, bus.cur_step);
    end
    repeat (3) begin
      bus.step_tick = 1'b1; cyc(); bus.step_tick = 1'b0;
      tests_run++;
      if (bus.cur_step !== '0 || bus.gate !== 1'b0 || bus.tone_num !== t0) begin
        tests_failed++;
        $display("FAIL pause_tick: cur=%0d gate=%0b tone=%0d expected 0 0 %0d", bus.cur_step, bus.gate, bus.tone_num, t0);
      end
    end
    bus.pause = 1'b1; cyc(); bus.pause = 1'b0;
    tests_run++;
    if (bus.gate !== 1'b1 || bus.tone_rst_n !== 1'b0 || bus.cur_step !== '0 || bus.tone_num !== t0) begin
      tests_failed++;
      $display("FAIL pause_resume: gate=%0b rst_n=%0b cur=%0d tone=%0d expected 1 0 0 %0d",
               bus.gate, bus.tone_rst_n, bus.cur_step, bus.tone_num, t0);
    end
    cyc();
    tests_run++;
    if (bus.tone_rst_n !== 1'b1 || bus.gate !== 1'b1) begin
      tests_failed++;
      $display("FAIL pause_pulse: rst_n=%0b gate=%0b expected 1 1", bus.tone_rst_n, bus.gate);
    end
    bus.pause = 1'b1; cyc(); bus.pause = 1'b0;
    bus.start = 1'b1; cyc(); bus.start = 1'b0;
    tests_run++;
    if (bus.gate !== 1'b1 || bus.tone_rst_n !== 1'b0) begin
      tests_failed++;
      $display("FAIL start_resume: gate=%0b rst_n=%0b expected 1 0", bus.gate, bus.tone_rst_n);
    end
    bus.step_tick = 1'b1; cyc(); bus.step_tick = 1'b0; cyc();
    tests_run++;
    if (bus.cur_step !== AW'(1) || bus.tone_num !== ref_period(8'h55)) begin
      tests_failed++;
      $display("FAIL pause_after: cur=%0d tone=%0d expected 1 %0d", bus.cur_step, bus.tone_num, ref_period(8'h55));
    end
    m_tone = ref_period(8'h55);
    bus.stop = 1'b1; cyc(); bus.stop = 1'b0;
  endtask

  task automatic test_priority();
    bus.len = AW'(1); bus.loop_en = 1'b1;
    bus.start = 1'b1; cyc(); bus.start = 1'b0; cyc(); cyc();
    bus.stop = 1'b1; bus.pause = 1'b1; bus.step_tick = 1'b1; cyc();
    bus.stop = 1'b0; bus.pause = 1'b0; bus.step_tick = 1'b0;
    tests_run++;
    if (bus.busy !== 1'b0 || bus.cur_step !== '0 || bus.gate !== 1'b0 || bus.done !== 1'b0) begin
      tests_failed++;
      $display("FAIL prio_stop: busy=%0b cur=%0d gate=%0b done=%0b expected 0 0 0 0",
               bus.busy, bus.cur_step, bus.gate, bus.done);
    end
    cyc();
    tests_run++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL prio_after: done=%0b busy=%0b expected 0 0", bus.done, bus.busy);
    end
    bus.start = 1'b1; cyc(); bus.start = 1'b0; cyc();
    bus.step_tick = 1'b1; cyc(); bus.step_tick = 1'b0; cyc();
    do_reset();
    tests_run++;
    if (bus.tone_num !== 32'd0 || bus.tone_rst_n !== 1'b1 || bus.gate !== 1'b0 ||
        bus.cur_step !== '0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      tests_failed++;
      $display("FAIL mid_reset: tone=%0d rst_n=%0b gate=%0b cur=%0d busy=%0b done=%0b expected 0 1 0 0 0 0",
               bus.tone_num, bus.tone_rst_n, bus.gate, bus.cur_step, bus.busy, bus.done);
    end
    run_pattern(3, 1'b0, 4, "cleared");
  endtask

  task automatic test_rbw();
    wr_step(0, 8'h61); wr_step(1, 8'h62); wr_step(2, 8'h63);
    bus.len = AW'(2); bus.loop_en = 1'b1;
    bus.start = 1'b1; cyc(); bus.start = 1'b0; cyc();
    bus.step_tick = 1'b1; cyc(); bus.step_tick = 1'b0; cyc();
    bus.step_tick = 1'b1; cyc(); bus.step_tick = 1'b0;
    bus.wr_en = 1'b1; bus.wr_addr = AW'(2); bus.wr_data = 8'h58; cyc(); bus.wr_en = 1'b0;
    m_pat[2] = 8'h58;
    tests_run++;
    if (bus.cur_step !== AW'(2) || bus.tone_num !== ref_period(8'h63)) begin
      tests_failed++;
      $display("FAIL rbw_old: cur=%0d tone=%0d expected 2 %0d", bus.cur_step, bus.tone_num, ref_period(8'h63));
    end
    repeat (3) begin
      bus.step_tick = 1'b1; cyc(); bus.step_tick = 1'b0; cyc();
    end
    tests_run++;
    if (bus.cur_step !== AW'(2) || bus.tone_num !== ref_period(8'h58)) begin
      tests_failed++;
      $display("FAIL rbw_new: cur=%0d tone=%0d expected 2 %0d", bus.cur_step, bus.tone_num, ref_period(8'h58));
    end
    m_tone = ref_period(8'h58);
    bus.stop = 1'b1; cyc(); bus.stop = 1'b0;
  endtask

  task automatic test_random();
    logic [7:0] d;
    int len;
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 16; i++) begin
        if (i > 0 && $urandom_range(0, 3) == 0) d = {1'b1, m_pat[i-1][6:0]};
        else d = 8'($urandom);
        wr_step(i, d);
      end
      len = $urandom_range(0, 15);
      run_pattern(len, (r != 3), len + 1 + $urandom_range(0, 4), "random");
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_pattern();
    test_tie();
    test_pause();
    test_priority();
    test_rbw();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
